pdp11_fetch: RTL and testbench

PDP11_FETCH -- requirements
Module: pdp11_fetch

---
 rtl/pdp11_fetch_pkg.sv | 17 +
 rtl/fetch_buffer.sv | 54 +++++
 rtl/pdp11_fetch.sv | 133 +++++++++++++
 tb/tb_pdp11_fetch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp11_fetch_pkg.sv
// rtl/pdp11_fetch_pkg.sv - shared types and constants for the PDP-11 instruction fetch unit
package pdp11_fetch_pkg;

  localparam int PC_W = 16;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0] word;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - prefetch FIFO of {word, pc} entries with flush; DEPTH must be a power of two
module fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 head_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];
  assign full      = (cnt == CW'(DEPTH));
  assign empty     = (cnt == '0);
  assign count     = cnt;

endmodule

// File: rtl/pdp11_fetch.sv
// rtl/pdp11_fetch.sv - PDP-11 instruction prefetch unit, one outstanding flash read, redirect flush
// Optional odd-redirect fault detection enabled by defining FETCH_ALIGN_CHECK_EN.
module pdp11_fetch
  import pdp11_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'o000000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [14:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_word,
  output logic [15:0] instr_pc,
  output logic        fetch_fault
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] req_pc;
  logic [PC_W-1:0] redirect_target;
  logic            fault;
  logic            can_issue;
  logic            push;
  logic            pop;
  logic            buf_full;
  logic            buf_empty;
  logic [CNT_W-1:0] buf_count;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redirect_target = redirect_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      fault <= 1'b0;
    end else if (redirect_valid) begin
      fault <= redirect_pc[0];
    end
  end
`else
  assign redirect_target = redirect_pc & {{(PC_W-1){1'b1}}, 1'b0};
  assign fault           = 1'b0;
`endif

  // A redirect cycle never issues: the PC is about to change underneath it.
  assign can_issue = !reset && !halt && !redirect_valid && !fault &&
                     (buf_count < CNT_W'(BUF_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (can_issue) state_nxt = WAIT;
      end
      WAIT: begin
        if (redirect_valid) begin
          state_nxt = mem_rvalid ? FETCH : DISCARD;
        end else if (mem_rvalid) begin
          state_nxt = FETCH;
        end
      end
      DISCARD: begin
        if (mem_rvalid) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    mem_req     = (state == FETCH) && can_issue;
    push        = (state == WAIT) && mem_rvalid && !redirect_valid && !buf_full;
    instr_valid = !buf_empty;
    pop         = !buf_empty && instr_ready;
    instr_word  = buf_empty ? '0 : head_entry.word;
    instr_pc    = buf_empty ? '0 : head_entry.pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      if (redirect_valid) begin
        pc <= redirect_target;
      end else if (push) begin
        pc <= pc + PC_W'(2);
      end
      if (mem_req) req_pc <= pc;
    end
  end

  assign mem_addr        = pc[PC_W-1:1];
  assign fetch_fault     = fault;
  assign push_entry.word = mem_rdata;
  assign push_entry.pc   = req_pc;

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_buffer (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_pdp11_fetch.sv
// tb/tb_pdp11_fetch.sv - scoreboard bench for pdp11_fetch with a variable-latency flash model
module tb_pdp11_fetch;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        halt;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_word;
  logic [15:0] instr_pc;
  logic        fetch_fault;

  int checks = 0;
  int failures = 0;
  int req_count = 0;
  int rel_cyc = 0;
  int lat = 1;
  int rem = 0;
  logic [14:0] paddr = '0;
  logic [15:0] flash [32768];

  logic [31:0] exp_q[$];
  logic [14:0] exp_addr_q[$];
  int          req_cyc_q[$];

  pdp11_fetch #(.RESET_PC(16'o000000), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_word     (instr_word),
    .instr_pc       (instr_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  // Flash model: one pending read, response after lat cycles, cleared by reset.
  always @(posedge clk) begin
    if (reset) begin
      rem <= 0;
    end else if (mem_req) begin
      rem   <= lat;
      paddr <= mem_addr;
    end else if (rem != 0) begin
      rem <= rem - 1;
    end
  end
  assign mem_rvalid = (rem == 1);
  assign mem_rdata  = mem_rvalid ? flash[paddr] : 16'h0000;

  always @(posedge clk) rel_cyc <= reset ? 0 : rel_cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0o required=%0o", name, act, exp);
    end
  endtask

  // Monitor: compares every request address and every accepted instruction.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_req) begin
        req_count++;
        req_cyc_q.push_back(rel_cyc + 1);
        if (exp_addr_q.size() > 0) begin
          check("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
        end else begin
          check("mem_req_unexpected", 32'(mem_addr), 32'h7fffffff);
        end
      end
      if (instr_valid && instr_ready) begin
        if (exp_q.size() > 0) begin
          check("instr_word_pc", {instr_word, instr_pc}, exp_q.pop_front());
        end else begin
          check("instr_unexpected", {instr_word, instr_pc}, 32'hffffffff);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    halt = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'o000000;
    instr_ready = 1'b1;
    tick(2);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_instr_valid", 32'(instr_valid), 0);
    check("rst_instr_word", 32'(instr_word), 0);
    check("rst_instr_pc", 32'(instr_pc), 0);
    check("rst_fetch_fault", 32'(fetch_fault), 0);
    exp_q.delete();
    exp_addr_q.delete();
    req_cyc_q.delete();
    req_count = 0;
    reset = 1'b0;
  endtask

  task automatic end_test(input string name);
    check({name, "_sb_left"}, 32'(exp_q.size()), 0);
    check({name, "_addr_left"}, 32'(exp_addr_q.size()), 0);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) flash[i] = 16'(i * 3 + 16'o070000);
    flash[0]     = 16'o012700;
    flash[1]     = 16'o000005;
    flash[2]     = 16'o005200;
    flash[256]   = 16'o123456;
    flash[32767] = 16'o170017;

    // Straight-line fetch, latency 1: requests in cycles 1, 3, 5.
    lat = 1;
    do_reset();
    exp_addr_q = '{15'd0, 15'd1, 15'd2};
    exp_q = '{{16'o012700, 16'o000000}, {16'o000005, 16'o000002}, {16'o005200, 16'o000004}};
    tick(5);
    halt = 1'b1;
    tick(6);
    check("t1_req_n", 32'(req_cyc_q.size()), 3);
    if (req_cyc_q.size() == 3) begin
      check("t1_req_cyc0", 32'(req_cyc_q[0]), 1);
      check("t1_req_cyc1", 32'(req_cyc_q[1]), 3);
      check("t1_req_cyc2", 32'(req_cyc_q[2]), 5);
    end
    end_test("t1");

    // Back-pressure: buffer fills at DEPTH, a single pop frees exactly one request.
    do_reset();
    instr_ready = 1'b0;
    exp_addr_q = '{15'd0, 15'd1, 15'd2};
    exp_q = '{{16'o012700, 16'o000000}, {16'o000005, 16'o000002}, {16'o005200, 16'o000004}};
    tick(10);
    check("t2_full_reqs", 32'(req_count), 32'(DEPTH));
    instr_ready = 1'b1;
    tick(1);
    instr_ready = 1'b0;
    tick(5);
    check("t2_after_pop_reqs", 32'(req_count), 32'(DEPTH + 1));
    halt = 1'b1;
    instr_ready = 1'b1;
    tick(5);
    check("t2_drain_reqs", 32'(req_count), 32'(DEPTH + 1));
    end_test("t2");

    // Redirect while waiting at latency 3: stale response discarded.
    lat = 3;
    do_reset();
    exp_addr_q = '{15'd0, 15'o400};
    exp_q = '{{16'o123456, 16'o001000}};
    tick(1);
    redirect_valid = 1'b1;
    redirect_pc = 16'o001000;
    tick(1);
    redirect_valid = 1'b0;
    tick(3);
    halt = 1'b1;
    tick(6);
    check("t3_reqs", 32'(req_count), 2);
    end_test("t3");

    // PC wrap from 177776 to 000000.
    lat = 1;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 16'o177776;
    exp_addr_q = '{15'o77777, 15'd0};
    exp_q = '{{16'o170017, 16'o177776}, {16'o012700, 16'o000000}};
    tick(1);
    redirect_valid = 1'b0;
    tick(3);
    halt = 1'b1;
    tick(5);
    check("t4_reqs", 32'(req_count), 2);
    end_test("t4");

    // Halt during WAIT: response still delivered, no new request until released.
    lat = 3;
    do_reset();
    exp_addr_q = '{15'd0, 15'd1};
    exp_q = '{{16'o012700, 16'o000000}, {16'o000005, 16'o000002}};
    tick(1);
    halt = 1'b1;
    tick(8);
    check("t5_halted_reqs", 32'(req_count), 1);
    check("t5_first_popped", 32'(exp_q.size()), 1);
    halt = 1'b0;
    tick(1);
    halt = 1'b1;
    tick(6);
    check("t5_resumed_reqs", 32'(req_count), 2);
    end_test("t5");

    // Odd redirect.
    lat = 1;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 16'o000003;
`ifdef FETCH_ALIGN_CHECK_EN
    tick(1);
    redirect_valid = 1'b0;
    tick(4);
    check("t6_fault_set", 32'(fetch_fault), 1);
    check("t6_fault_valid", 32'(instr_valid), 0);
    check("t6_fault_reqs", 32'(req_count), 0);
    exp_addr_q = '{15'd2};
    exp_q = '{{16'o005200, 16'o000004}};
    redirect_valid = 1'b1;
    redirect_pc = 16'o000004;
    tick(1);
    redirect_valid = 1'b0;
    check("t6_fault_clear", 32'(fetch_fault), 0);
    tick(1);
    halt = 1'b1;
    tick(4);
    check("t6_reqs", 32'(req_count), 1);
`else
    exp_addr_q = '{15'd1};
    exp_q = '{{16'o000005, 16'o000002}};
    tick(1);
    redirect_valid = 1'b0;
    tick(1);
    halt = 1'b1;
    tick(5);
    check("t6_no_fault", 32'(fetch_fault), 0);
    check("t6_reqs", 32'(req_count), 1);
`endif
    end_test("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
